uart_rx_dram_writer: RTL and testbench

- UART receiver, 8N1, LSB first: the receive-side counterpart of the board's transmit path.
- Deserialises the serial line, checks framing, and writes each good byte into the on-chip DRAM at an auto-incrementing address.
- Also presents each byte on a strobe interface.
- Sits between the board RX pin and the DRAM data/address/wren port, clocked by the same slow system clock as the rest of the design.

---
 rtl/uart_rx_dram_writer_pkg.sv | 23 ++
 rtl/bit_sync2.sv | 32 +++
 rtl/uart_rx_dram_writer.sv | 141 ++++++++++++++
 tb/tb_uart_rx_dram_writer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_dram_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_dram_writer_pkg
// Description : Shared state encodings and UART frame constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_dram_writer_pkg;

  localparam int       DATA_BITS  = 8;
  localparam logic     STOP_LEVEL = 1'b1;
  localparam logic     IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/bit_sync2.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync2
// Description : Two-flop synchroniser for a single asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_dram_writer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_dram_writer
// Description : 8N1 UART receiver writing each good byte to DRAM at an
//               auto-incrementing, wrapping address.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_dram_writer
  import uart_rx_dram_writer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 16,
  parameter int ADDR_DEPTH   = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              rx_busy,
  output logic [7:0]        dram_data,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_wren,
  output logic [2:0]        state_out
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int                IDX_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_CNT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDR_DEPTH - 1);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 ferr_q, ferr_d;

  bit_sync2 #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_in),
    .q_o   (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rxs == 1'b0) state_d = ST_START;
      end
      ST_START: begin
        // Sampling mid start bit rejects glitches shorter than half a bit.
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (rxs == 1'b0) ? ST_DATA : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d = '0;
          if (rxs == STOP_LEVEL) begin
            byte_d  = shift_q;
            state_d = ST_WRITE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        if (rxs == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data   = byte_q;
  assign dram_data = byte_q;
  assign dram_addr = addr_q;
  assign rx_valid  = (state_q == ST_WRITE);
  assign dram_wren = (state_q == ST_WRITE);
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != ST_IDLE);
  assign state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_dram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_dram_writer
// Description : Self-checking bench for uart_rx_dram_writer (8 clk/bit, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_dram_writer;

  localparam int CPB   = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic [7:0]    rx_data, dram_data;
  logic          rx_valid, frame_err, rx_busy, dram_wren;
  logic [AW-1:0] dram_addr;
  logic [2:0]    state_out;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] wr_addr[$];
  logic [7:0]    wr_data[$];
  int            ferr_cnt  = 0;
  logic          prev_wren = 1'b0;

  typedef struct {
    logic [7:0]    data;
    logic          stop;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx_dram_writer #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW),
    .ADDR_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy),
    .dram_data (dram_data),
    .dram_addr (dram_addr),
    .dram_wren (dram_wren),
    .state_out (state_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event recorder and per-cycle invariants on write/error strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dram_wren || rx_valid) begin
        check("valid_eq_wren", 32'(rx_valid), 32'(dram_wren));
        check("rxdata_eq_dramdata", 32'(rx_data), 32'(dram_data));
        check("wren_single_cycle", 32'(prev_wren & dram_wren), 32'd0);
        if (dram_wren) begin
          wr_addr.push_back(dram_addr);
          wr_data.push_back(dram_data);
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        check("ferr_not_with_valid", 32'(rx_valid), 32'd0);
      end
      prev_wren = dram_wren;
    end else begin
      prev_wren = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic do_reset();
    rx_in = 1'b1;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    wr_addr.delete();
    wr_data.delete();
    ferr_cnt = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_data"},   32'(rx_data),   32'd0);
    check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_rx_busy"},   32'(rx_busy),   32'd0);
    check({tag, "_dram_data"}, 32'(dram_data), 32'd0);
    check({tag, "_dram_addr"}, 32'(dram_addr), 32'd0);
    check({tag, "_dram_wren"}, 32'(dram_wren), 32'd0);
    check({tag, "_state"},     32'(state_out), 32'd0);
  endtask

  initial begin
    int            n0, f0;
    logic [AW-1:0] cur_addr;
    logic [7:0]    last_good;
    logic [7:0]    partial;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'd0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'd1};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'd2};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 8'd3};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'd3};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 8'd0};

    do_reset();
    check_reset_values("reset");
    cur_addr  = '0;
    last_good = 8'h00;

    // Table-driven single frames, including wrap 3->0 and a bad stop bit.
    for (int i = 0; i < 6; i++) begin
      n0 = wr_addr.size();
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      rx_in = 1'b1;
      idle(12);
      if (vecs[i].exp_wr) begin
        check("vec_write_count", 32'(wr_addr.size() - n0), 32'd1);
        if (wr_addr.size() > n0) begin
          check("vec_write_addr", 32'(wr_addr[n0]), 32'(vecs[i].exp_addr));
          check("vec_write_data", 32'(wr_data[n0]), 32'(vecs[i].data));
        end
        check("vec_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        last_good = vecs[i].data;
        cur_addr  = (vecs[i].exp_addr == AW'(DEPTH - 1)) ? '0 : vecs[i].exp_addr + 1'b1;
      end else begin
        check("vec_no_write", 32'(wr_addr.size() - n0), 32'd0);
        check("vec_one_ferr", 32'(ferr_cnt - f0), 32'd1);
      end
      check("vec_addr_after", 32'(dram_addr), 32'(cur_addr));
      check("vec_rx_data_hold", 32'(rx_data), 32'(last_good));
      check("vec_busy_low", 32'(rx_busy), 32'd0);
      check("vec_state_idle", 32'(state_out), 32'd0);
    end

    // Short low glitch: START aborts, nothing strobes.
    n0 = wr_addr.size();
    f0 = ferr_cnt;
    rx_in = 1'b0;
    idle(2);
    rx_in = 1'b1;
    idle(20);
    check("glitch_no_write", 32'(wr_addr.size() - n0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_addr", 32'(dram_addr), 32'(cur_addr));
    check("glitch_state", 32'(state_out), 32'd0);

    // Framing error with line held low (break): single error, WAIT_HIGH.
    n0 = wr_addr.size();
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k % 10 == 9) check("break_wait_high", 32'(state_out), 32'd5);
    end
    check("break_one_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("break_no_write", 32'(wr_addr.size() - n0), 32'd0);
    rx_in = 1'b1;
    idle(4);
    check("break_release_idle", 32'(state_out), 32'd0);
    check("break_rx_data_hold", 32'(rx_data), 32'(last_good));
    send_frame(8'h11, 1'b1);
    idle(12);
    check("after_break_count", 32'(wr_addr.size() - n0), 32'd1);
    if (wr_addr.size() > n0) begin
      check("after_break_addr", 32'(wr_addr[n0]), 32'(cur_addr));
      check("after_break_data", 32'(wr_data[n0]), 32'h11);
    end

    // Back-to-back frames from address 0 with wrap.
    do_reset();
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    idle(12);
    check("b2b_count", 32'(wr_addr.size()), 32'd5);
    for (int b = 0; b < 5; b++) begin
      if (b < wr_addr.size()) begin
        check("b2b_addr", 32'(wr_addr[b]), 32'(b % DEPTH));
        check("b2b_data", 32'(wr_data[b]), 32'(b + 1));
      end
    end
    check("b2b_addr_after", 32'(dram_addr), 32'd1);

    // Asynchronous reset during data bit 4.
    wr_addr.delete();
    wr_data.delete();
    partial = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    rx_in = partial[4];
    idle(4);
    check("midframe_in_data", 32'(state_out), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    rx_in = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    check("async_rst_no_write", 32'(wr_addr.size()), 32'd0);
    send_frame(8'h7E, 1'b1);
    idle(12);
    check("post_rst_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("post_rst_addr", 32'(wr_addr[0]), 32'd0);
      check("post_rst_data", 32'(wr_data[0]), 32'h7E);
    end
    check("post_rst_rx_data", 32'(rx_data), 32'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
